pixel_dispatcher: RTL

Parametrised work scheduler between the pixel cursor and a bank of `NUM_CORES` raymarcher cores. It hands out pixel coordinates one per cycle to idle cores, in raster or interlaced order, and advances a frame counter. Each core's result is buffered in its own holding register, and results are merged round-robin into a single valid/ready frame-buffer write stream. No result is lost when several cores finish in the same cycle.

---
 rtl/pixel_dispatcher.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_dispatcher.sv
// Purpose: hands pixel coordinates to idle raymarcher cores and merges their results into one frame-buffer write stream.
// Latency: start_out is registered (1 cycle after the decision); done_in in cycle n gives we_out in cycle n+2 when uncontended.
// Backpressure: wr_ready_in low freezes the output register; full holds block re-dispatch of their core, and no result is dropped.
module pixel_dispatcher #(
    parameter int WIDTH     = 1280,
    parameter int HEIGHT    = 720,
    parameter int NUM_CORES = 4,
    parameter int COLOR_W   = 24,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH * HEIGHT)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         enable_in,
    input  logic                         scan_mode_in,
    output logic [NUM_CORES-1:0]         start_out,
    output logic [XW-1:0]                x_out,
    output logic [YW-1:0]                y_out,
    output logic [31:0]                  timer_out,
    input  logic [NUM_CORES-1:0]         done_in,
    input  logic [NUM_CORES*XW-1:0]      core_x_in,
    input  logic [NUM_CORES*YW-1:0]      core_y_in,
    input  logic [NUM_CORES*COLOR_W-1:0] core_color_in,
    output logic                         we_out,
    output logic [AW-1:0]                waddr_out,
    output logic [COLOR_W-1:0]           wdata_out,
    input  logic                         wr_ready_in,
    output logic                         err_out
);

    // Pointer width; a single-core build still needs a 1-bit pointer.
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    // Round-robin pick: lowest requesting index at or above ptr, else lowest overall.
    function automatic logic [PW-1:0] f_rr_pick(input logic [NUM_CORES-1:0] req,
                                                input logic [PW-1:0]        ptr);
        logic [PW-1:0] sel;
        logic          found;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                sel   = PW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!found && req[i]) begin
                sel   = PW'(i);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Index following idx, wrapping at the last core.
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] idx);
        if (idx == PW'(NUM_CORES - 1)) begin
            return '0;
        end
        return idx + PW'(1);
    endfunction

    // Per-core tracking and result holding registers.
    logic [NUM_CORES-1:0] r_busy;
    logic [NUM_CORES-1:0] r_hold_v;
    logic [XW-1:0]        r_hold_x     [NUM_CORES];
    logic [YW-1:0]        r_hold_y     [NUM_CORES];
    logic [COLOR_W-1:0]   r_hold_color [NUM_CORES];

    // Dispatch side state.
    logic [NUM_CORES-1:0] r_start;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    logic [XW-1:0]        r_cur_x;
    logic [YW-1:0]        r_cur_y;
    logic                 r_mode;
    logic                 r_first;
    logic [31:0]          r_timer;
    logic [PW-1:0]        r_disp_ptr;

    // Write side state.
    logic                 r_we;
    logic [AW-1:0]        r_waddr;
    logic [COLOR_W-1:0]   r_wdata;
    logic [PW-1:0]        r_wr_ptr;
    logic                 r_err;

    // Dispatch decision. A core whose start pulse is on the wire this cycle is
    // not yet busy, so it is excluded explicitly to avoid a double hand-out.
    logic [NUM_CORES-1:0] w_elig;
    logic                 w_disp;
    logic [PW-1:0]        w_disp_sel;
    logic [NUM_CORES-1:0] w_start_mask;

    assign w_elig       = ~r_busy & ~r_hold_v & ~r_start;
    assign w_disp       = enable_in && (|w_elig);
    assign w_disp_sel   = f_rr_pick(w_elig, r_disp_ptr);
    assign w_start_mask = NUM_CORES'(1) << w_disp_sel;

    // Scan mode is latched on the first dispatch of every frame; until then the
    // live input steers the step away from (0,0).
    logic            w_mode;
    logic            w_x_last;
    logic [YW:0]     w_y_plus2;
    logic [XW-1:0]   w_nx;
    logic [YW-1:0]   w_ny;
    logic            w_frame_end;

    assign w_mode    = r_first ? scan_mode_in : r_mode;
    assign w_x_last  = (r_cur_x == XW'(WIDTH - 1));
    assign w_y_plus2 = {1'b0, r_cur_y} + (YW+1)'(2);

    // Next cursor position in raster or interlaced (evens then odds) order.
    always_comb begin
        w_nx        = r_cur_x + XW'(1);
        w_ny        = r_cur_y;
        w_frame_end = 1'b0;
        if (w_x_last) begin
            w_nx = '0;
            if (!w_mode) begin
                if (r_cur_y == YW'(HEIGHT - 1)) begin
                    w_frame_end = 1'b1;
                end else begin
                    w_ny = r_cur_y + YW'(1);
                end
            end else begin
                if (w_y_plus2 < (YW+1)'(HEIGHT)) begin
                    w_ny = w_y_plus2[YW-1:0];
                end else if (!r_cur_y[0] && (HEIGHT > 1)) begin
                    w_ny = YW'(1);
                end else begin
                    w_frame_end = 1'b1;
                end
            end
        end
        if (w_frame_end) begin
            w_nx = '0;
            w_ny = '0;
        end
    end

    // Issue start pulses, advance the cursor and count finished frames.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_start    <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_mode     <= 1'b0;
            r_first    <= 1'b1;
            r_timer    <= '0;
            r_disp_ptr <= '0;
        end else begin
            r_start <= '0;
            if (w_disp) begin
                r_start    <= w_start_mask;
                r_x        <= r_cur_x;
                r_y        <= r_cur_y;
                r_cur_x    <= w_nx;
                r_cur_y    <= w_ny;
                r_disp_ptr <= f_next(w_disp_sel);
                r_first    <= w_frame_end;
                if (r_first) begin
                    r_mode <= scan_mode_in;
                end
                if (w_frame_end) begin
                    r_timer <= r_timer + 32'd1;
                end
            end
        end
    end

    // Write merge: the output register reloads when empty or being accepted.
    logic                 w_load;
    logic                 w_wr_any;
    logic [PW-1:0]        w_wr_sel;
    logic [NUM_CORES-1:0] w_hold_clr;
    logic [AW-1:0]        w_waddr;
    logic [NUM_CORES-1:0] w_done_ok;
    logic [NUM_CORES-1:0] w_done_bad;

    assign w_load     = !r_we || wr_ready_in;
    assign w_wr_any   = |r_hold_v;
    assign w_wr_sel   = f_rr_pick(r_hold_v, r_wr_ptr);
    assign w_hold_clr = (w_load && w_wr_any) ? (NUM_CORES'(1) << w_wr_sel) : '0;
    assign w_waddr    = AW'(r_hold_x[w_wr_sel]) + AW'(AW'(WIDTH) * AW'(r_hold_y[w_wr_sel]));
    assign w_done_ok  = done_in & r_busy;
    assign w_done_bad = done_in & ~r_busy;

    // Busy/hold bookkeeping; a done from an idle core is flagged and dropped.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy   <= '0;
            r_hold_v <= '0;
            r_err    <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_hold_x[i]     <= '0;
                r_hold_y[i]     <= '0;
                r_hold_color[i] <= '0;
            end
        end else begin
            r_busy   <= (r_busy & ~done_in) | r_start;
            r_hold_v <= (r_hold_v & ~w_hold_clr) | w_done_ok;
            r_err    <= r_err | (|w_done_bad);
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_done_ok[i]) begin
                    r_hold_x[i]     <= core_x_in[i*XW +: XW];
                    r_hold_y[i]     <= core_y_in[i*YW +: YW];
                    r_hold_color[i] <= core_color_in[i*COLOR_W +: COLOR_W];
                end
            end
        end
    end

    // Output write register; fields only change on a load, so a stall holds them.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_wr_ptr <= '0;
        end else if (w_load) begin
            r_we <= w_wr_any;
            if (w_wr_any) begin
                r_waddr  <= w_waddr;
                r_wdata  <= r_hold_color[w_wr_sel];
                r_wr_ptr <= f_next(w_wr_sel);
            end
        end
    end

    assign start_out = r_start;
    assign x_out     = r_x;
    assign y_out     = r_y;
    assign timer_out = r_timer;
    assign we_out    = r_we;
    assign waddr_out = r_waddr;
    assign wdata_out = r_wdata;
    assign err_out   = r_err;

endmodule
